// File: rtl/keypad_matrix_scan_pkg.sv
// Shared keypad scan definitions: column drive patterns, debounce states, frame results.
package keypad_matrix_scan_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned COL_W    = 2;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned DWELL_W  = 8;

    // Walking-zero column patterns, identical to the digit scanner's anode drive
    localparam logic [NUM_COLS-1:0] COL0_PAT = 4'b1110;
    localparam logic [NUM_COLS-1:0] COL1_PAT = 4'b1101;
    localparam logic [NUM_COLS-1:0] COL2_PAT = 4'b1011;
    localparam logic [NUM_COLS-1:0] COL3_PAT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_PRESSED = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } frame_res_e;

    typedef struct packed {
        frame_res_e          kind;
        logic [CODE_W-1:0]   code;
    } frame_result_t;

    // Column index to active-low one-hot drive pattern
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] col);
        logic [NUM_COLS-1:0] pat;
        case (col)
            2'd0:    pat = COL0_PAT;
            2'd1:    pat = COL1_PAT;
            2'd2:    pat = COL2_PAT;
            default: pat = COL3_PAT;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/keypad_matrix_scan_if.sv
// Keypad matrix pins and debounced key event outputs.
interface keypad_matrix_scan_if;
    import keypad_matrix_scan_pkg::*;

    logic [NUM_ROWS-1:0] row_in;
    logic [NUM_COLS-1:0] col_out;
    logic [CODE_W-1:0]   key_code;
    logic                key_valid;
    logic                key_press;
    logic                key_release;
    logic                multi_key;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_press,
        output key_release,
        output multi_key
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_press,
        input  key_release,
        input  multi_key
    );

endinterface

// File: rtl/keypad_matrix_scan_sync_2ff.sv
// Two-flop synchronizer for asynchronous row lines; resets to idle (all ones).
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x4 keypad scanner: walking-zero column drive, per-frame key decode, frame debounce FSM.
module keypad_matrix_scan
    import keypad_matrix_scan_pkg::*;
#(
    parameter int unsigned DWELL           = 4,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic                 base_scan_clock,
    input  logic                 RESETn,
    keypad_matrix_scan_if.master kp
);

    logic [NUM_ROWS-1:0] row_sync;

    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [NUM_COLS-1:0] col_out_q, col_out_d;
    logic [1:0]          acc_cnt_q, acc_cnt_d;
    logic [CODE_W-1:0]   acc_code_q, acc_code_d;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_press_q, key_press_d;
    logic                key_release_q, key_release_d;
    logic                multi_key_q, multi_key_d;

    logic                sample_c;
    logic                eval_c;
    logic [1:0]          hits_c;
    logic [CODE_W-1:0]   hit_code_c;
    logic [2:0]          sum_c;
    logic [1:0]          tot_cnt_c;
    logic [CODE_W-1:0]   tot_code_c;
    frame_result_t       res_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic                cnt_done_c;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_sync (
        .clk   (base_scan_clock),
        .rst_n (RESETn),
        .d_i   (kp.row_in),
        .q_o   (row_sync)
    );

    // Sample on the last dwell cycle of a column; the frame closes on column 3
    assign sample_c = (dwell_q == DWELL_W'(DWELL - 1));
    assign eval_c   = sample_c && (col_q == COL_W'(NUM_COLS - 1));

    // Dwell counter and column stepping
    always_comb begin
        dwell_d   = dwell_q + DWELL_W'(1);
        col_d     = col_q;
        if (sample_c) begin
            dwell_d = '0;
            col_d   = col_q + COL_W'(1);
        end
        col_out_d = col_drive(col_d);
    end

    // Decode the current column's rows and fold them into the frame totals
    always_comb begin
        hits_c     = 2'd0;
        hit_code_c = '0;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            if (!row_sync[r]) begin
                if (hits_c != 2'd2) hits_c = hits_c + 2'd1;
                hit_code_c = {2'(r), col_q};
            end
        end
        sum_c      = {1'b0, acc_cnt_q} + {1'b0, hits_c};
        tot_cnt_c  = (sum_c >= 3'd2) ? 2'd2 : sum_c[1:0];
        tot_code_c = (hits_c != 2'd0) ? hit_code_c : acc_code_q;
        res_c.code = tot_code_c;
        case (tot_cnt_c)
            2'd0:    res_c.kind = RES_NONE;
            2'd1:    res_c.kind = RES_SINGLE;
            default: res_c.kind = RES_MULTI;
        endcase
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (eval_c) begin
            acc_cnt_d  = 2'd0;
            acc_code_d = '0;
        end else if (sample_c) begin
            acc_cnt_d  = tot_cnt_c;
            acc_code_d = tot_code_c;
        end
    end

    assign cnt_inc_c  = cnt_q + CNT_W'(1);
    assign cnt_done_c = (cnt_inc_c == CNT_W'(DEBOUNCE_FRAMES));

    // Debounce FSM, stepped once per frame result
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;
        multi_key_d   = 1'b0;
        if (eval_c) begin
            multi_key_d = (res_c.kind == RES_MULTI);
            case (state_q)
                ST_IDLE: begin
                    if (res_c.kind == RES_SINGLE) begin
                        cand_d = res_c.code;
                        cnt_d  = CNT_W'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = res_c.code;
                            key_valid_d = 1'b1;
                            key_press_d = 1'b1;
                        end else begin
                            state_d = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (res_c.kind == RES_SINGLE && res_c.code == cand_q) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_done_c) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_press_d = 1'b1;
                        end
                    end else if (res_c.kind == RES_SINGLE) begin
                        cand_d = res_c.code;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (res_c.kind == RES_NONE ||
                        (res_c.kind == RES_SINGLE && res_c.code != key_code_q)) begin
                        cnt_d = CNT_W'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d       = ST_IDLE;
                            key_valid_d   = 1'b0;
                            key_release_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                default: begin
                    if (res_c.kind == RES_SINGLE && res_c.code == key_code_q) begin
                        state_d = ST_PRESSED;
                    end else if (res_c.kind != RES_MULTI) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_done_c) begin
                            state_d       = ST_IDLE;
                            key_valid_d   = 1'b0;
                            key_release_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge base_scan_clock or negedge RESETn) begin
        if (!RESETn) begin
            dwell_q       <= '0;
            col_q         <= '0;
            col_out_q     <= COL0_PAT;
            acc_cnt_q     <= '0;
            acc_code_q    <= '0;
            state_q       <= ST_IDLE;
            cand_q        <= '0;
            cnt_q         <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            multi_key_q   <= 1'b0;
        end else begin
            dwell_q       <= dwell_d;
            col_q         <= col_d;
            col_out_q     <= col_out_d;
            acc_cnt_q     <= acc_cnt_d;
            acc_code_q    <= acc_code_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            multi_key_q   <= multi_key_d;
        end
    end

    assign kp.col_out     = col_out_q;
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_press   = key_press_q;
    assign kp.key_release = key_release_q;
    assign kp.multi_key   = multi_key_q;

endmodule
